// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: two-entry pipeline register with a skid slot.
//
// A main register drives out_data. A second (skid) register catches one
// extra beat when downstream stalls. This lets in_ready come straight
// from a flop, with no combinational path from out_ready. Throughput
// stays at one beat per cycle.
//
// Parameters
//   DATA_W     payload width (instruction + PC packed)
//   FLUSH_VAL  out_data value after reset or flush
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active low
//   flush      discard held and same-cycle incoming entries
//   in_valid   upstream offers in_data
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts
//   out_data   payload from the main register
//   occupancy  number of entries held (0..2)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, out_valid=0, in_ready=1
// ST_ONE   | main holds the head entry, skid free
// ST_TWO   | main holds the head entry, skid holds the next; in_ready=0

module pipe_reg_skid #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [DATA_W-1:0]   w_main_nxt;
  logic [DATA_W-1:0]   w_skid_nxt;
  logic                r_in_ready;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_out_valid;

  // Handshake decode. in_ready is a flop, so the input transfer depends
  // only on in_valid and registered state.
  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    w_in_xfer   = in_valid & r_in_ready;
    w_out_xfer  = w_out_valid & out_ready;
  end

  // Next-state and datapath steering.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      // Flush wins over both transfers. A same-cycle output transfer has
      // already been seen by downstream. Incoming data is simply dropped.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = FLUSH_VAL;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end else if (w_out_xfer) begin
            // main keeps its value so out_data holds the last entry
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so no input transfer can occur
          if (w_out_xfer) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = FLUSH_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= FLUSH_VAL;
      r_skid     <= FLUSH_VAL;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      // Registered copy of "next state is not TWO". It is low for exactly
      // the cycles spent in TWO.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_TWO:   occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  localparam int          W  = 64;
  localparam logic [63:0] FV = 64'hDEAD_BEEF_0000_F1F1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  pipe_reg_skid #(.DATA_W(W), .FLUSH_VAL(FV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  // Behavioural model: a FIFO of held entries (at most two), plus the
  // value that out_data is expected to show.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_od = FV;
  bit           m_ir, m_ov, m_ix, m_ox;
  int           n_delivered = 0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_od = FV;
    end else begin
      m_ir = (mq.size() < 2);
      m_ov = (mq.size() > 0);
      m_ix = in_valid && m_ir;
      m_ox = m_ov && out_ready;
      if (m_ox) n_delivered++;
      if (flush) begin
        mq.delete();
        m_od = FV;
      end else begin
        if (m_ox) void'(mq.pop_front());
        if (m_ix) mq.push_back(in_data);
        if (mq.size() > 0) m_od = mq[0];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
      chk("out_data",  out_data,       m_od);
    end
  end

  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [63:0] d, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input int occ, input logic ov,
                           input logic ir, input logic [63:0] od);
    chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
    chk({tag, ".ov"},  64'(out_valid), 64'(ov));
    chk({tag, ".ir"},  64'(in_ready),  64'(ir));
    chk({tag, ".od"},  out_data,       od);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    cyc(0, 0, 0, 64'h0, 0);
    chk_en = 1;
    expect_st("reset", 0, 0, 1, FV);

    // Stream 1,2,3 with downstream always ready
    cyc(1, 0, 1, 64'h1, 1); expect_st("stream1", 1, 1, 1, 64'h1);
    cyc(1, 0, 1, 64'h2, 1); expect_st("stream2", 1, 1, 1, 64'h2);
    cyc(1, 0, 1, 64'h3, 1); expect_st("stream3", 1, 1, 1, 64'h3);
    cyc(1, 0, 0, 64'h0, 1); expect_st("drain",   0, 0, 1, 64'h3);

    // Backpressure: A then B with out_ready low
    cyc(1, 0, 1, 64'hA, 0); expect_st("bp_a",    1, 1, 1, 64'hA);
    cyc(1, 0, 1, 64'hB, 0); expect_st("bp_b",    2, 1, 0, 64'hA);
    cyc(1, 0, 1, 64'hE, 0); expect_st("bp_hold", 2, 1, 0, 64'hA);
    cyc(1, 0, 0, 64'h0, 1); expect_st("bp_outa", 1, 1, 1, 64'hB);
    cyc(1, 0, 0, 64'h0, 1); expect_st("bp_outb", 0, 0, 1, 64'hB);

    // Flush in TWO with a same-cycle push of 0xC
    cyc(1, 0, 1, 64'h11, 0);
    cyc(1, 0, 1, 64'h12, 0); expect_st("pre_fl", 2, 1, 0, 64'h11);
    cyc(1, 1, 1, 64'hC, 0);  expect_st("flush",  0, 0, 1, FV);
    cyc(1, 0, 0, 64'h0, 1);  expect_st("post_fl", 0, 0, 1, FV);

    // Simultaneous in/out in ONE
    cyc(1, 0, 1, 64'h5, 0); expect_st("sim5", 1, 1, 1, 64'h5);
    cyc(1, 0, 1, 64'h6, 1); expect_st("sim6", 1, 1, 1, 64'h6);

    // Reset mid-stream in TWO
    cyc(1, 0, 1, 64'h21, 0); expect_st("pre_rst", 2, 1, 0, 64'h6);
    cyc(0, 0, 1, 64'h99, 1); expect_st("mid_rst", 0, 0, 1, FV);
    cyc(1, 0, 1, 64'h7, 0);  expect_st("push7",   1, 1, 1, 64'h7);

    // Randomized run, phases vary ready/valid density
    for (int i = 0; i < 10000; i++) begin
      int ph;
      logic r, f, iv, ordy;
      ph   = i / 2000;
      r    = ($urandom_range(0, 299) != 0);
      f    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 9) < (ph == 1 ? 9 : 6));
      ordy = ($urandom_range(0, 9) < (ph == 2 ? 2 : (ph == 3 ? 9 : 6)));
      cyc(r, f, iv, {$urandom, $urandom}, ordy);
    end

    cyc(1, 0, 0, 64'h0, 1);
    cyc(1, 0, 0, 64'h0, 1);
    expect_st("final", 0, 0, 1, m_od);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
